win_checker: RTL and testbench
==============================

# win_checker

Sequential four-in-a-row detector for the 6×7 board. On a start pulse it latches the board, scans every cell and direction at one check per clock, and reports the first winning player, a draw, or no result. Its `winner` output drives the `player` input of the winner-screen drawer. The game FSM uses `done` to decide whether to show the winner screen.

## Interface
- `ROWS`, default 6: board rows; row 0 is the top row.
- `COLS`, default 7: board columns; column 0 is the leftmost column.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: one-cycle request to check the board. Honoured only in IDLE.
- `board` input, 84 bits: cell (r,c) occupies bits [2(r·7+c)+1 : 2(r·7+c)].
  - 00 = empty, 01 = player 1 (red), 10 = player 2 (yellow).
  - 11 is treated as empty.
- `busy` output, 1 bit: high while a scan is in progress.
- `done` output, 1 bit: one-cycle pulse when a result is valid.
- `winner` output, 3 bits: 000 = none, 001 = player 1, 010 = player 2, 011 = draw.
  - Held until the next accepted start.

## Operation
- States:
  - IDLE → SCAN on `start`.
  - SCAN → FINISH when a win is found or the last check completes.
  - FINISH → IDLE unconditionally.
- On an accepted `start`:
  - Latch `board` into an internal copy.
  - Clear `winner` to 000.
  - Zero the check counter k and the full flag.
  - Changes to `board` during the scan are ignored.
- Check index k = 4·(r·7+c) + d, for k = 0..167. Cells are scanned row-major; d cycles fastest.
- Directions and in-bounds conditions:
  - d=0, horizontal right: c ≤ 3.
  - d=1, vertical down: r ≤ 2.
  - d=2, diagonal down-right: r ≤ 2 and c ≤ 3.
  - d=3, diagonal down-left: r ≤ 2 and c ≥ 3.
- A check hits when it is in bounds, the base cell is 01 or 10, and the next three cells along d equal the base cell.
  - Out-of-bounds checks still consume one cycle and never hit. Rows must not wrap; e.g. (r,4..6) plus (r+1,0) is not a line.
- Full flag is the AND over all 42 cells of "cell ≠ 00 and cell ≠ 11". It is computed from the latched copy.
- On a hit at check k:
  - `winner` ← the base cell's code, zero-extended.
  - Go to FINISH immediately. Remaining checks are skipped; the first hit in scan order wins.
- After check 167 with no hit:
  - `winner` ← 011 if the full flag is set, else 000.
  - Go to FINISH.
- FINISH asserts `done` for exactly one cycle.
- `start` while `busy` is ignored. `start` during FINISH is also ignored.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `winner`=000, k=0.
- Reset mid-scan forces these values on the next edge. No `done` pulse follows.
- Latency, with `start` sampled at edge 0:
  - `busy` is high from cycle 1.
  - Check k is evaluated in cycle 1+k.
  - A hit at check k gives `done`=1 and a valid `winner` in cycle 2+k.
  - With no hit, `done` is in cycle 169.
- `busy` is high in SCAN only and drops in the cycle `done` rises.
- In the cycle after `done`, the block is in IDLE and accepts `start`.
- `winner` changes only on an accepted start (cleared) and on entry to FINISH (result).

## Test plan
- Empty board, `start` → `done` in cycle 169, `winner`=000, `busy` high in cycles 1–168.
- Player 1 at (5,0)–(5,3), rest empty → hit at k=140; `done` in cycle 142, `winner`=001.
- Player 2 at (2,6)–(5,6) vertical → hit at k=81; `done` in cycle 83, `winner`=010.
- Player 1 on the diagonal (2,3),(3,2),(4,1),(5,0) → hit at k=71 (d=3); `done` in cycle 73, `winner`=001.
- Non-wrapping edge case: player 1 at (4,4),(4,5),(4,6),(5,0), others empty → `winner`=000, `done` in cycle 169.
- Draw board (full checkerboard-in-pairs pattern, no line):
  - Result: `winner`=011 at cycle 169.
  - A second `start` at cycle 50 is ignored.
  - A rerun with `rst` at cycle 60 → outputs 000/0/0, no `done` pulse.

Source files
------------

// File: rtl/win_checker.sv
// Four-in-a-row detector: latches a board on start, then walks every cell and
// direction at one check per clock and reports the first win, a draw, or none.
module win_checker #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2*ROWS*COLS-1:0] board,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             winner
);
    localparam int CELLS = ROWS * COLS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    // Handshake: start is a one-cycle request honoured only in IDLE; done is a
    // one-cycle pulse in FINISH and winner is stable from then until the next
    // accepted start. busy is high exactly while the scan runs.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2*CELLS-1:0] board_q;
    logic [RW-1:0]      row;
    logic [CW-1:0]      col;
    logic [1:0]         dir;
    logic [1:0]         base;
    logic               in_bounds;
    logic               hit;
    logic               full;
    logic               last;
    int                 step_r;
    int                 step_c;

    // Out-of-range coordinates read as empty so they can never extend a line.
    function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b, input int r, input int c);
        logic [1:0] v;
        v = 2'b00;
        for (int p = 0; p < CELLS; p++) begin
            if (r >= 0 && r < ROWS && c >= 0 && c < COLS && p == r * COLS + c) begin
                v = b[2*p +: 2];
            end
        end
        return v;
    endfunction

    always_comb begin
        full = 1'b1;
        for (int p = 0; p < CELLS; p++) begin
            if (board_q[2*p +: 2] == 2'b00 || board_q[2*p +: 2] == 2'b11) begin
                full = 1'b0;
            end
        end
    end

    always_comb begin
        step_r = 0;
        step_c = 1;
        case (dir)
            2'd0:    begin step_r = 0; step_c = 1;  end
            2'd1:    begin step_r = 1; step_c = 0;  end
            2'd2:    begin step_r = 1; step_c = 1;  end
            default: begin step_r = 1; step_c = -1; end
        endcase
        in_bounds = (int'(row) + 3 * step_r < ROWS) &&
                    (int'(col) + 3 * step_c < COLS) &&
                    (int'(col) + 3 * step_c >= 0);
        base = cell_at(board_q, int'(row), int'(col));
        hit  = in_bounds && (base == 2'b01 || base == 2'b10);
        for (int i = 1; i < 4; i++) begin
            if (cell_at(board_q, int'(row) + i * step_r, int'(col) + i * step_c) != base) begin
                hit = 1'b0;
            end
        end
        last = (row == LAST_ROW) && (col == LAST_COL) && (dir == 2'd3);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (hit || last) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            board_q <= '0;
            row     <= '0;
            col     <= '0;
            dir     <= 2'd0;
            winner  <= 3'b000;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        board_q <= board;
                        winner  <= 3'b000;
                        row     <= '0;
                        col     <= '0;
                        dir     <= 2'd0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        winner <= {1'b0, base};
                    end else if (last) begin
                        winner <= full ? 3'b011 : 3'b000;
                    end else begin
                        // Direction is the fastest-moving part of the check index.
                        dir <= dir + 2'd1;
                        if (dir == 2'd3) begin
                            if (col == LAST_COL) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SCAN);
    assign done = (state == FINISH);

endmodule

// File: tb/tb_win_checker.sv
// Bench for win_checker: fixed scenarios from a vector table, hand-written
// multi-cycle corner sequences, and random boards against a reference model.
module tb_win_checker;
    localparam int ROWS = 6;
    localparam int COLS = 7;
    localparam int BW   = 2 * ROWS * COLS;
    localparam int MAXC = 400;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BW-1:0] board;
    logic          busy;
    logic          done;
    logic [2:0]    winner;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string         name;
        logic [BW-1:0] b;
        int            exp_cyc;
        int            exp_w;
    } vec_t;

    vec_t vecs[8];

    win_checker #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .board(board),
        .busy(busy),
        .done(done),
        .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int r, input int c,
                                          input logic [1:0] v);
        logic [BW-1:0] t;
        t = b;
        t[2*(r*COLS+c) +: 2] = v;
        return t;
    endfunction

    function automatic logic [BW-1:0] draw_board();
        logic [BW-1:0] t;
        t = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                t = put(t, r, c, (((c / 2) + r) % 2 == 1) ? 2'b10 : 2'b01);
        return t;
    endfunction

    function automatic logic [BW-1:0] rand_board(input int fill_pct, input bit allow_11);
        logic [BW-1:0] t;
        int v;
        t = '0;
        for (int p = 0; p < ROWS * COLS; p++) begin
            if (int'($urandom_range(99)) < fill_pct) begin
                v = allow_11 ? int'($urandom_range(3)) : int'($urandom_range(2, 1));
                t[2*p +: 2] = 2'(v);
            end
        end
        return t;
    endfunction

    // Reference: try every (cell, direction) in scan order on a 2-D grid.
    function automatic void model(input logic [BW-1:0] b, output int cyc, output int w);
        int  g[ROWS][COLS];
        int  dr[4];
        int  dc[4];
        bit  full;
        bit  line;
        int  r, c, d, rr, cc;
        dr = '{0, 1, 1, 1};
        dc = '{1, 0, 1, -1};
        full = 1'b1;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                g[i][j] = int'(b[2*(i*COLS+j) +: 2]);
                if (g[i][j] == 3) g[i][j] = 0;
                if (g[i][j] == 0) full = 1'b0;
            end
        end
        for (int k = 0; k < 4 * ROWS * COLS; k++) begin
            r = (k / 4) / COLS;
            c = (k / 4) % COLS;
            d = k % 4;
            line = (g[r][c] != 0);
            for (int i = 1; i < 4; i++) begin
                rr = r + i * dr[d];
                cc = c + i * dc[d];
                if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) line = 1'b0;
                else if (g[rr][cc] != g[r][c]) line = 1'b0;
            end
            if (line) begin
                cyc = k + 2;
                w   = g[r][c];
                return;
            end
        end
        cyc = 4 * ROWS * COLS + 1;
        w   = full ? 3 : 0;
    endfunction

    // Called at a falling edge; start is sampled at the next rising edge (edge 0),
    // so the n-th falling edge afterwards lies in cycle n.
    task automatic run_scan(input logic [BW-1:0] b, input int inj_cyc, input logic [BW-1:0] inj_b,
                            input bit scramble, input bit fin_start, output int done_cyc,
                            output int w, output bit busy_ok, output bit after_ok);
        logic [95:0] noise;
        board    = b;
        start    = 1'b1;
        done_cyc = -1;
        w        = -1;
        busy_ok  = 1'b1;
        after_ok = 1'b0;
        for (int cyc = 1; cyc <= MAXC && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                done_cyc = cyc;
                w = int'(winner);
                if (busy) busy_ok = 1'b0;
                if (fin_start) start = 1'b1;
            end else begin
                if (!busy || winner != 3'b000) busy_ok = 1'b0;
                if (cyc == inj_cyc) begin
                    start = 1'b1;
                    board = inj_b;
                end else if (scramble) begin
                    noise = {$urandom(), $urandom(), $urandom()};
                    board = noise[BW-1:0];
                end
            end
        end
        if (done_cyc > 0) begin
            @(negedge clk);
            start = 1'b0;
            after_ok = !done && !busy && (int'(winner) == w);
        end
    endtask

    task automatic scan_and_check(input string name, input logic [BW-1:0] b, input int inj_cyc,
                                  input logic [BW-1:0] inj_b, input bit scramble, input bit fin_start,
                                  input int exp_cyc, input int exp_w);
        int dcyc, w;
        bit bok, aok;
        run_scan(b, inj_cyc, inj_b, scramble, fin_start, dcyc, w, bok, aok);
        check({name, " done_cycle"}, dcyc, exp_cyc);
        check({name, " winner"}, w, exp_w);
        check({name, " busy_during_scan"}, int'(bok), 1);
        check({name, " idle_after_done"}, int'(aok), 1);
    endtask

    initial begin
        logic [BW-1:0] b;
        logic [BW-1:0] win_b;
        int ecyc, ew, seen;

        rst   = 1'b1;
        start = 1'b0;
        board = '0;
        repeat (3) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset winner", int'(winner), 0);
        rst = 1'b0;
        @(negedge clk);

        vecs[0] = '{"empty", '0, 169, 0};
        b = '0;
        for (int c = 0; c < 4; c++) b = put(b, 5, c, 2'b01);
        vecs[1] = '{"p1_bottom_row", b, 142, 1};
        win_b = b;
        b = '0;
        for (int r = 2; r < 6; r++) b = put(b, r, 6, 2'b10);
        vecs[2] = '{"p2_vertical", b, 83, 2};
        b = '0;
        for (int i = 0; i < 4; i++) b = put(b, 2 + i, 3 - i, 2'b01);
        vecs[3] = '{"p1_diag_left", b, 73, 1};
        b = '0;
        b = put(b, 4, 4, 2'b01);
        b = put(b, 4, 5, 2'b01);
        b = put(b, 4, 6, 2'b01);
        b = put(b, 5, 0, 2'b01);
        vecs[4] = '{"no_row_wrap", b, 169, 0};
        vecs[5] = '{"draw", draw_board(), 169, 3};
        vecs[6] = '{"all_code_11", '1, 169, 0};
        b = '0;
        for (int i = 0; i < 4; i++) b = put(b, 0, 3 + i, 2'b10);
        for (int i = 0; i < 4; i++) b = put(b, i, 0, 2'b01);
        vecs[7] = '{"first_hit_wins", b, 3, 1};

        for (int i = 0; i < 8; i++)
            scan_and_check(vecs[i].name, vecs[i].b, -1, '0, 1'b0, 1'b0, vecs[i].exp_cyc, vecs[i].exp_w);

        // A start pulse mid-scan with a winning board must be ignored.
        scan_and_check("draw_restart_ignored", draw_board(), 50, win_b, 1'b0, 1'b0, 169, 3);

        // Start during FINISH is dropped; start in the following IDLE cycle is taken.
        scan_and_check("start_in_finish", vecs[2].b, -1, '0, 1'b0, 1'b1, 83, 2);
        scan_and_check("start_right_after", vecs[3].b, -1, '0, 1'b0, 1'b0, 73, 1);

        // Reset in the middle of a scan.
        board = draw_board();
        start = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midscan_rst busy", int'(busy), 0);
        check("midscan_rst done", int'(done), 0);
        check("midscan_rst winner", int'(winner), 0);
        seen = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("midscan_rst no_activity", seen, 0);

        for (int t = 0; t < 30; t++) begin
            case (t % 3)
                0:       b = rand_board(25, 1'b1);
                1:       b = rand_board(55, 1'b1);
                default: b = rand_board(95, 1'b0);
            endcase
            model(b, ecyc, ew);
            scan_and_check($sformatf("rand%0d", t), b, -1, '0, 1'b1, 1'b0, ecyc, ew);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
